// File: rtl/dhm_pkg.sv
// dhm_pkg: shared states, symbol constants and tie-break helper for the mode sequencer
package dhm_pkg;
    localparam int SYM_W = 2;
    localparam int NSYM = 4;
    localparam bit TIE_LOW_FIRST = 1'b1;
    typedef enum logic [1:0] {IDLE, ACC, EVAL, HOLD} state_t;
    function automatic logic beats(input logic [7:0] a, input logic [7:0] b);
        return TIE_LOW_FIRST ? a > b : a >= b;
    endfunction
endpackage

// File: rtl/dhm_mode_seq_if.sv
// dhm_mode_seq_if: symbol input and result output handshakes of the mode sequencer
interface dhm_mode_seq_if #(parameter int WIN = 8);
    import dhm_pkg::*;
    localparam int CW = $clog2(WIN + 1);
    logic in_valid, in_ready, in_last, out_valid, out_ready;
    logic [SYM_W-1:0] in_data, out_max;
    logic [CW-1:0] out_cnt0, out_cnt1, out_cnt2, out_cnt3, out_len;
    modport master(
        output in_valid, in_data, in_last, out_ready,
        input in_ready, out_valid, out_max, out_cnt0, out_cnt1, out_cnt2, out_cnt3, out_len
    );
    modport slave(
        input in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_cnt0, out_cnt1, out_cnt2, out_cnt3, out_len
    );
endinterface

// File: rtl/dhm_argmax4.sv
// dhm_argmax4: combinational argmax over four counts, lower symbol wins ties
module dhm_argmax4 import dhm_pkg::*; #(
    parameter int CW = 4
) (
    input  logic [CW-1:0]    c0,
    input  logic [CW-1:0]    c1,
    input  logic [CW-1:0]    c2,
    input  logic [CW-1:0]    c3,
    output logic [SYM_W-1:0] win
);
    logic [CW-1:0] m01, m23;
    logic [SYM_W-1:0] w01, w23;
    always_comb begin
        w01 = beats(8'(c1), 8'(c0)) ? 2'd1 : 2'd0;
        m01 = w01[0] ? c1 : c0;
        w23 = beats(8'(c3), 8'(c2)) ? 2'd3 : 2'd2;
        m23 = w23[0] ? c3 : c2;
        win = beats(8'(m23), 8'(m01)) ? w23 : w01;
    end
endmodule

// File: rtl/dhm_mode_seq.sv
// dhm_mode_seq: serial 2-bit symbol window counter producing the most frequent symbol
module dhm_mode_seq import dhm_pkg::*; #(
    parameter int WIN = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dhm_mode_seq_if.slave bus,
    output logic          busy
);
    localparam int CW = $clog2(WIN + 1);
    state_t state, state_nxt;
    logic [CW-1:0] cnt [NSYM];
    logic [CW-1:0] len;
    logic [SYM_W-1:0] winner;
    logic accept, close, taking;
    always_comb begin
        taking = state == IDLE || state == ACC;
        accept = bus.in_valid && taking;
        close = bus.in_last || len == CW'(WIN - 1);
        state_nxt = taking ? (accept ? (close ? EVAL : ACC) : state)
                  : state == EVAL ? HOLD
                  : (bus.out_ready ? IDLE : HOLD);
    end
    assign bus.in_ready = taking;
    assign bus.out_valid = state == HOLD;
    assign busy = state != IDLE;
    dhm_argmax4 #(.CW(CW)) u_argmax (
        .c0(cnt[0]), .c1(cnt[1]), .c2(cnt[2]), .c3(cnt[3]), .win(winner)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '{default: '0};
            len <= '0;
            bus.out_max <= '0;
            bus.out_cnt0 <= '0;
            bus.out_cnt1 <= '0;
            bus.out_cnt2 <= '0;
            bus.out_cnt3 <= '0;
            bus.out_len <= '0;
        end else begin
            state <= state_nxt;
            if (state == HOLD && bus.out_ready) begin
                cnt <= '{default: '0};
                len <= '0;
            end else if (accept) begin
                cnt[bus.in_data] <= cnt[bus.in_data] + 1'b1;
                len <= len + 1'b1;
            end
            if (state == EVAL) begin
                bus.out_max <= winner;
                bus.out_cnt0 <= cnt[0];
                bus.out_cnt1 <= cnt[1];
                bus.out_cnt2 <= cnt[2];
                bus.out_cnt3 <= cnt[3];
                bus.out_len <= len;
            end
        end
    end
endmodule

// File: tb/tb_dhm_mode_seq.sv
// tb_dhm_mode_seq: directed checks of windowing, argmax ties, backpressure and reset
module tb_dhm_mode_seq;
    logic clk, rst_n, busy;
    int checks = 0;
    int errors = 0;

    dhm_mode_seq_if #(.WIN(8)) bus();
    dhm_mode_seq #(.WIN(8)) dut(.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

    wire [21:0] res = {bus.out_max, bus.out_cnt0, bus.out_cnt1, bus.out_cnt2, bus.out_cnt3, bus.out_len};

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [1:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1; bus.in_data = d; bus.in_last = l;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.out_ready = 0;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (res !== 22'h0) begin errors++; $display("FAIL reset_outputs: got %h exp 000000", res); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0] syms [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        bus.out_ready = 1;
        foreach (syms[i]) send(syms[i], 0);
        @(negedge clk); bus.in_valid = 0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_eval_valid: got %b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_eval_ready: got %b exp 0", bus.in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b exp 1", busy); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid: got %b exp 1", bus.out_valid); end
        checks++; if (res !== {2'd0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd8}) begin errors++; $display("FAIL b2b_result: got %h exp %h", res, {2'd0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd8}); end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_release: in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_all_three();
        bus.out_ready = 1;
        repeat (8) send(2'd3, 0);
        @(negedge clk); bus.in_valid = 0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL all3_valid: got %b exp 1", bus.out_valid); end
        checks++; if (res !== {2'd3, 4'd0, 4'd0, 4'd0, 4'd8, 4'd8}) begin errors++; $display("FAIL all3_result: got %h exp %h", res, {2'd3, 4'd0, 4'd0, 4'd0, 4'd8, 4'd8}); end
        @(negedge clk);
    endtask

    task automatic test_early_last();
        bus.out_ready = 1;
        send(2'd2, 0); send(2'd1, 0); send(2'd2, 1);
        @(negedge clk); bus.in_valid = 0; bus.in_last = 0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL last_ready: got %b exp 0", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL last_valid: got %b exp 1", bus.out_valid); end
        checks++; if (res !== {2'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd3}) begin errors++; $display("FAIL last_result: got %h exp %h", res, {2'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd3}); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [1:0] syms [8] = '{1, 1, 3, 3, 3, 0, 0, 1};
        bus.out_ready = 0;
        foreach (syms[i]) send(syms[i], 0);
        @(negedge clk); bus.in_valid = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (res !== {2'd1, 4'd2, 4'd3, 4'd0, 4'd3, 4'd8} || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: res=%h valid=%b ready=%b exp %h/1/0", c, res, bus.out_valid, bus.in_ready, {2'd1, 4'd2, 4'd3, 4'd0, 4'd3, 4'd8});
            end
        end
        bus.out_ready = 1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release: ready=%b valid=%b busy=%b exp 1/0/0", bus.in_ready, bus.out_valid, busy);
        end
    endtask

    task automatic test_gaps();
        int exp [4] = '{0, 0, 0, 0};
        logic [1:0] d, m;
        int gap;
        bus.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.in_valid = 0; bus.in_last = 1; bus.in_data = 2'($urandom);
                @(posedge clk);
            end
            d = 2'($urandom);
            exp[d]++;
            send(d, 0);
        end
        m = 0;
        for (int s = 1; s < 4; s++) if (exp[s] > exp[m]) m = 2'(s);
        @(negedge clk); bus.in_valid = 0; bus.in_last = 0;
        @(negedge clk);
        checks++; if (res !== {m, 4'(exp[0]), 4'(exp[1]), 4'(exp[2]), 4'(exp[3]), 4'd8} || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL gaps_result: got %h valid=%b exp %h/1", res, bus.out_valid, {m, 4'(exp[0]), 4'(exp[1]), 4'(exp[2]), 4'(exp[3]), 4'd8});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [1:0] syms [5] = '{0, 1, 2, 3, 0};
        bus.out_ready = 1;
        foreach (syms[i]) send(syms[i], 0);
        @(negedge clk); bus.in_valid = 0; rst_n = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: valid=%b ready=%b busy=%b exp 0/1/0", bus.out_valid, bus.in_ready, busy);
        end
        checks++; if (res !== 22'h0) begin errors++; $display("FAIL rstmid_outputs: got %h exp 000000", res); end
        @(negedge clk); rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_novalid%0d: got %b exp 0", c, bus.out_valid); end
        end
        repeat (8) send(2'd0, 0);
        @(negedge clk); bus.in_valid = 0;
        @(negedge clk);
        checks++; if (res !== {2'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd8} || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_fresh: got %h valid=%b exp %h/1", res, bus.out_valid, {2'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd8});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_all_three();
        test_early_last();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
